// File: rtl/input_debounce.sv
// ---------------------------------------------------------------------------
// input_debounce
//
// Purpose:
//   Conditions a raw, asynchronous control input (switch or pin) into the
//   clean, registered level A that the downstream control FSM consumes.
//   Din first passes through a two-flop synchroniser. A four-state counter
//   FSM then debounces it: the FSM needs DEBOUNCE consecutive synchronised
//   samples at the new level before A changes. The block also emits
//   one-cycle Rise/Fall strobes and keeps a saturating count of aborted
//   debounce attempts for diagnostics.
//
// Parameters:
//   DEBOUNCE  consecutive synchronised samples needed to change A (1..255)
//   CNT_W     stability counter width, 2**CNT_W must exceed DEBOUNCE
//   GLITCH_W  width of GlitchCnt
//
// Ports:
//   Clock      in   single system clock, rising edge
//   Reset      in   synchronous, active-high reset
//   Din        in   raw asynchronous input
//   A          out  debounced, registered level
//   Rise       out  one-cycle pulse in the cycle A goes 0->1
//   Fall       out  one-cycle pulse in the cycle A goes 1->0
//   Busy       out  high while a level change is being qualified
//   GlitchCnt  out  saturating count of aborted debounce attempts
// ---------------------------------------------------------------------------
module input_debounce #(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 8,
    parameter int GLITCH_W = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Din,
    output logic                A,
    output logic                Rise,
    output logic                Fall,
    output logic                Busy,
    output logic [GLITCH_W-1:0] GlitchCnt
);

    typedef enum logic [1:0] {
        LOW    = 2'b00,
        CHK_HI = 2'b01,
        HIGH   = 2'b10,
        CHK_LO = 2'b11
    } state_t;

    // Value of the counter on the last qualifying sample before A may flip.
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic                r_s1;
    logic                r_s2;
    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_a;
    logic                r_rise;
    logic                r_fall;
    logic [GLITCH_W-1:0] r_glitch;

    state_t              w_stateNext;
    logic [CNT_W-1:0]    w_cntNext;
    logic                w_aNext;
    logic                w_riseNext;
    logic                w_fallNext;
    logic [GLITCH_W-1:0] w_glitchNext;
    logic [GLITCH_W-1:0] w_glitchInc;

    // An aborted attempt bumps the glitch counter, holding at all-ones.
    assign w_glitchInc = (r_glitch == '1) ? r_glitch : r_glitch + GLITCH_W'(1);

    // State register: the synchroniser, the FSM state and every registered
    // output. Reset wins over any transition on the same edge, so a reset
    // taken while A is high drops A without producing a Fall strobe.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_state  <= LOW;
            r_cnt    <= '0;
            r_a      <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_glitch <= '0;
        end else begin
            r_s1     <= Din;
            r_s2     <= r_s1;
            r_state  <= w_stateNext;
            r_cnt    <= w_cntNext;
            r_a      <= w_aNext;
            r_rise   <= w_riseNext;
            r_fall   <= w_fallNext;
            r_glitch <= w_glitchNext;
        end
    end

    // Next-state logic. The FSM looks only at the synchronised sample r_s2.
    // r_cnt holds the number of consecutive samples seen at the candidate
    // level. A sample back at the old level abandons the attempt and counts
    // as a glitch. With DEBOUNCE=1 the check states are skipped entirely.
    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = r_cnt;
        w_aNext      = r_a;
        w_riseNext   = 1'b0;
        w_fallNext   = 1'b0;
        w_glitchNext = r_glitch;
        case (r_state)
            LOW: begin
                if (r_s2) begin
                    if (DEBOUNCE == 1) begin
                        w_stateNext = HIGH;
                        w_aNext     = 1'b1;
                        w_riseNext  = 1'b1;
                        w_cntNext   = '0;
                    end else begin
                        w_stateNext = CHK_HI;
                        w_cntNext   = CNT_W'(1);
                    end
                end
            end
            CHK_HI: begin
                if (!r_s2) begin
                    w_stateNext  = LOW;
                    w_cntNext    = '0;
                    w_glitchNext = w_glitchInc;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_stateNext = HIGH;
                    w_aNext     = 1'b1;
                    w_riseNext  = 1'b1;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!r_s2) begin
                    if (DEBOUNCE == 1) begin
                        w_stateNext = LOW;
                        w_aNext     = 1'b0;
                        w_fallNext  = 1'b1;
                        w_cntNext   = '0;
                    end else begin
                        w_stateNext = CHK_LO;
                        w_cntNext   = CNT_W'(1);
                    end
                end
            end
            CHK_LO: begin
                if (r_s2) begin
                    w_stateNext  = HIGH;
                    w_cntNext    = '0;
                    w_glitchNext = w_glitchInc;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_stateNext = LOW;
                    w_aNext     = 1'b0;
                    w_fallNext  = 1'b1;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_stateNext = LOW;
                w_aNext     = 1'b0;
                w_cntNext   = '0;
            end
        endcase
    end

    // Output decode: Busy comes straight from the state. Every other output
    // is already a flop.
    always_comb begin
        Busy = (r_state == CHK_HI) || (r_state == CHK_LO);
    end

    assign A         = r_a;
    assign Rise      = r_rise;
    assign Fall      = r_fall;
    assign GlitchCnt = r_glitch;

endmodule

// File: tb/tb_input_debounce.sv
// ---------------------------------------------------------------------------
// tb_input_debounce
//
// Testbench for input_debounce. It drives two instances from the same
// stimulus, one built with DEBOUNCE=4 and one with DEBOUNCE=1. A behavioural
// model tracks each instance: it delays Din by two samples, then counts how
// long the delayed level has differed from A. A directed vector table and a
// few hand-written sequences pin down exact cycle timing.
// ---------------------------------------------------------------------------
module tb_input_debounce;

    logic       clock;
    logic       reset;
    logic       din;

    logic       a4, rise4, fall4, busy4;
    logic [7:0] glitch4;
    logic       a1, rise1, fall1, busy1;
    logic [7:0] glitch1;

    int total;
    int bad;

    input_debounce #(.DEBOUNCE(4), .CNT_W(8), .GLITCH_W(8)) dut4 (
        .Clock     (clock),
        .Reset     (reset),
        .Din       (din),
        .A         (a4),
        .Rise      (rise4),
        .Fall      (fall4),
        .Busy      (busy4),
        .GlitchCnt (glitch4)
    );

    input_debounce #(.DEBOUNCE(1), .CNT_W(8), .GLITCH_W(8)) dut1 (
        .Clock     (clock),
        .Reset     (reset),
        .Din       (din),
        .A         (a1),
        .Rise      (rise1),
        .Fall      (fall1),
        .Busy      (busy1),
        .GlitchCnt (glitch1)
    );

    // Free-running clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model state, index 0 tracks dut4 and index 1 tracks dut1.
    int deb  [2] = '{4, 1};
    int mS1  [2];
    int mS2  [2];
    int mA   [2];
    int mRun [2];
    int mGl  [2];
    int mRise[2];
    int mFall[2];

    typedef struct {
        logic       rst;
        logic       d;
        logic       expA;
        logic       expRise;
        logic       expFall;
        logic       expBusy;
        logic [7:0] expGlitch;
    } vec_t;

    // One comparison: step the counters and report any difference.
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // The model advances one clock edge. Rule: once the twice-delayed input
    // has differed from A for DEBOUNCE samples in a row, A flips. A run that
    // ends early counts as a glitch, saturating at 255.
    task automatic modelStep(input logic rst, input logic d);
        int oldS2;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mS1[k] = 0; mS2[k] = 0; mA[k] = 0; mRun[k] = 0;
                mGl[k] = 0; mRise[k] = 0; mFall[k] = 0;
            end else begin
                oldS2    = mS2[k];
                mS2[k]   = mS1[k];
                mS1[k]   = int'(d);
                mRise[k] = 0;
                mFall[k] = 0;
                if (oldS2 != mA[k]) begin
                    mRun[k]++;
                    if (mRun[k] == deb[k]) begin
                        mA[k]    = oldS2;
                        mRun[k]  = 0;
                        mRise[k] = oldS2;
                        mFall[k] = 1 - oldS2;
                    end
                end else begin
                    if (mRun[k] > 0 && mGl[k] < 255) mGl[k]++;
                    mRun[k] = 0;
                end
            end
        end
    endtask

    // Compare both instances against the model.
    task automatic checkOutput();
        chk("d4.A",         32'(a4),      32'(mA[0]));
        chk("d4.Rise",      32'(rise4),   32'(mRise[0]));
        chk("d4.Fall",      32'(fall4),   32'(mFall[0]));
        chk("d4.Busy",      32'(busy4),   32'(mRun[0] > 0));
        chk("d4.GlitchCnt", 32'(glitch4), 32'(mGl[0]));
        chk("d1.A",         32'(a1),      32'(mA[1]));
        chk("d1.Rise",      32'(rise1),   32'(mRise[1]));
        chk("d1.Fall",      32'(fall1),   32'(mFall[1]));
        chk("d1.Busy",      32'(busy1),   32'(mRun[1] > 0));
        chk("d1.GlitchCnt", 32'(glitch1), 32'(mGl[1]));
    endtask

    // Drive on the falling edge, then check 1 time unit after the rising edge.
    task automatic applyStimulus(input logic rst, input logic d);
        @(negedge clock);
        reset = rst;
        din   = d;
        @(posedge clock);
        modelStep(rst, d);
        #1;
        checkOutput();
    endtask

    vec_t vecs[$];
    int   nRise;
    int   nFall;
    int   busySeen;
    int   riseSeen;
    int   runLeft;
    logic lvl;
    logic rrst;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        din   = 1'b0;

        // Directed timing vectors for DEBOUNCE=4. Each row gives the state
        // just after its rising edge.
        //   rows  0-2  : reset for 3 cycles
        //   rows  3-9  : Din rises, A and Rise appear 5 edges later
        //   rows 10-16 : Din falls, A drops and Fall appears 5 edges later
        //   rows 17-23 : Din high for 2 cycles only, giving a glitch
        vecs = '{
            '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
            '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
            '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0},
            '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0},
            '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1}
        };
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].d);
            chk($sformatf("vec%0d.A", i),    32'(a4),      32'(vecs[i].expA));
            chk($sformatf("vec%0d.Rise", i), 32'(rise4),   32'(vecs[i].expRise));
            chk($sformatf("vec%0d.Fall", i), 32'(fall4),   32'(vecs[i].expFall));
            chk($sformatf("vec%0d.Busy", i), 32'(busy4),   32'(vecs[i].expBusy));
            chk($sformatf("vec%0d.Glit", i), 32'(glitch4), 32'(vecs[i].expGlitch));
        end

        // Reset taken while A is high: A drops with no Fall strobe. A then
        // returns on the 6th edge after release, because the synchroniser
        // has to refill before the 4 qualifying samples can start.
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1);
        chk("pre_reset.A", 32'(a4), 32'd1);
        applyStimulus(1'b1, 1'b1);
        chk("rst_high.A",    32'(a4),      32'd0);
        chk("rst_high.Fall", 32'(fall4),   32'd0);
        chk("rst_high.Busy", 32'(busy4),   32'd0);
        chk("rst_high.Glit", 32'(glitch4), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, 1'b1);
            chk($sformatf("rst_rearm%0d.A", i), 32'(a4), 32'd0);
        end
        applyStimulus(1'b0, 1'b1);
        chk("rst_rearm6.A",    32'(a4),    32'd1);
        chk("rst_rearm6.Rise", 32'(rise4), 32'd1);

        // 300 single-cycle pulses: dut4 never rises and the glitch count
        // saturates.
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        riseSeen = 0;
        for (int p = 0; p < 300; p++) begin
            applyStimulus(1'b0, 1'b1);
            if (rise4 === 1'b1) riseSeen++;
            for (int j = 0; j < 6; j++) begin
                applyStimulus(1'b0, 1'b0);
                if (rise4 === 1'b1) riseSeen++;
            end
        end
        chk("sat.GlitchCnt", 32'(glitch4), 32'd255);
        chk("sat.riseSeen",  32'(riseSeen), 32'd0);
        chk("sat.A",         32'(a4),       32'd0);

        // DEBOUNCE=1: Din toggles every 3 cycles, giving one strobe per
        // toggle and no Busy.
        applyStimulus(1'b1, 1'b0);
        nRise = 0; nFall = 0; busySeen = 0;
        lvl = 1'b0;
        for (int t = 0; t < 20; t++) begin
            lvl = ~lvl;
            for (int j = 0; j < 3; j++) begin
                applyStimulus(1'b0, lvl);
                if (rise1 === 1'b1) nRise++;
                if (fall1 === 1'b1) nFall++;
                if (busy1 !== 1'b0) busySeen++;
            end
        end
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b0, lvl);
            if (rise1 === 1'b1) nRise++;
            if (fall1 === 1'b1) nFall++;
            if (busy1 !== 1'b0) busySeen++;
        end
        chk("d1toggle.nRise",    32'(nRise),    32'd10);
        chk("d1toggle.nFall",    32'(nFall),    32'd10);
        chk("d1toggle.busySeen", 32'(busySeen), 32'd0);

        // Random runs of Din with occasional resets, checked by the model.
        runLeft = 0;
        lvl     = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (runLeft == 0) begin
                lvl     = 1'($urandom_range(0, 1));
                runLeft = $urandom_range(1, 8);
            end
            runLeft--;
            rrst = ($urandom_range(0, 59) == 0);
            applyStimulus(rrst, lvl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
